// File: rtl/uart_tx_arbiter_if.sv
// Requester / transmitter bundle of the shared UART_TX arbiter.
// The master modport is the arbiter; the slave modport is its environment.
interface uart_tx_arbiter_if #(
  parameter int unsigned N    = 4,
  parameter int unsigned size = 8
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]      req;
  logic [N*size-1:0] req_data;
  logic [N-1:0]      gnt;
  logic [IW-1:0]     gnt_id;
  logic [size-1:0]   tx_data;
  logic              tx_start;
  logic              tx_ready;
  logic              busy;
  logic              err;

  modport master (
    input  req, req_data, tx_ready,
    output gnt, gnt_id, tx_data, tx_start, busy, err
  );

  modport slave (
    output req, req_data, tx_ready,
    input  gnt, gnt_id, tx_data, tx_start, busy, err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX between N byte producers, with a
// timeout on the transmitter's start acknowledge.
module uart_tx_arbiter #(
  parameter int unsigned N           = 4,
  parameter int unsigned size        = 8,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  uart_tx_arbiter_if.master bus
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, WAIT_DONE} state_t;

  state_t            state;
  logic [IW-1:0]     last;
  logic [CW-1:0]     ack_cnt;
  logic [N-1:0]      gnt_r;
  logic [IW-1:0]     gnt_id_r;
  logic [size-1:0]   tx_data_r;
  logic              tx_start_r;
  logic              busy_r;
  logic              err_r;

  logic              found_c;
  logic [IW-1:0]     winner_c;
  logic [IW-1:0]     idx_c;
  logic [size-1:0]   byte_c [N];

  for (genvar g = 0; g < N; g++) begin : g_byte
    assign byte_c[g] = bus.req_data[g*size +: size];
  end

  // First set request after the last winner, wrapping modulo N.
  always_comb begin
    found_c  = 1'b0;
    winner_c = last;
    idx_c    = last;
    for (int unsigned k = 1; k <= N; k++) begin
      idx_c = IW'((32'(last) + k) % N);
      if (!found_c && bus.req[idx_c]) begin
        found_c  = 1'b1;
        winner_c = idx_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last       <= IW'(N - 1);
      ack_cnt    <= '0;
      gnt_r      <= '0;
      gnt_id_r   <= '0;
      tx_data_r  <= '0;
      tx_start_r <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      gnt_r <= '0;
      err_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tx_ready && found_c) begin
            tx_data_r <= byte_c[winner_c];
            gnt_id_r  <= winner_c;
            last      <= winner_c;
            gnt_r     <= N'(1) << winner_c;
            busy_r    <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          tx_start_r <= 1'b1;
          ack_cnt    <= '0;
          state      <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!bus.tx_ready) begin
            tx_start_r <= 1'b0;
            state      <= WAIT_DONE;
          end else if (ack_cnt == CW'(ACK_TIMEOUT)) begin
            // Transmitter never took the frame: drop it, keep rotation advanced.
            tx_start_r <= 1'b0;
            err_r      <= 1'b1;
            busy_r     <= 1'b0;
            state      <= IDLE;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (bus.tx_ready) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt      = gnt_r;
  assign bus.gnt_id   = gnt_id_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.tx_start = tx_start_r;
  assign bus.busy     = busy_r;
  assign bus.err      = err_r;
endmodule
